// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered PC, prioritised next-PC selection and an
// optional return-address stack compiled in with macro PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             ALUZero,
    input  logic             Jump,
    input  logic             JumpReg,
    input  logic             Exception,
    input  logic             Link,
    input  logic             Return,
    input  logic [25:0]      JumpField,
    input  logic [WIDTH-1:0] SignExtImm32,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] CurrentPC,
    output logic [WIDTH-1:0] NextPC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] RASTop,
    output logic             RASEmpty,
    output logic             RASMiss
);

    logic commit;
    logic unused_imm;

    // Exception forces the cycle to commit even while the pipeline is stalled.
    assign commit     = !Stall || Exception;
    assign PCPlus4    = CurrentPC + WIDTH'(4);
    assign unused_imm = &{1'b0, SignExtImm32[WIDTH-1:WIDTH-2]};

    always_comb begin
        NextPC = PCPlus4;
        if (Exception)
            NextPC = EXC_VECTOR;
        else if (JumpReg)
            NextPC = RegTarget;
        else if (Branch && ALUZero)
            NextPC = PCPlus4 + {SignExtImm32[WIDTH-3:0], 2'b00};
        else if (Jump)
            NextPC = {PCPlus4[WIDTH-1:28], JumpField, 2'b00};
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            CurrentPC <= RESET_VECTOR;
        else if (commit)
            CurrentPC <= NextPC;
    end

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             upd;
    logic             do_push;
    logic             do_pop;
    logic             do_repl;
    logic             grow;
    logic             wr_en;

    // ras_ptr addresses the next free slot; the top of stack sits one below it.
    assign top_idx   = ras_ptr - PW'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));

    assign upd     = commit && !Exception && !Reset;
    assign do_push = upd && Link && !Return;
    assign do_pop  = upd && JumpReg && Return && !Link;
    assign do_repl = upd && Link && Return;
    // A replace on an empty stack degenerates into a plain push.
    assign grow    = do_push || (do_repl && ras_empty);
    assign wr_en   = grow || do_repl;
    assign wr_idx  = grow ? ras_ptr : top_idx;

    always_ff @(posedge CLK) begin
        if (wr_en)
            ras_mem[wr_idx] <= PCPlus4;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (grow) begin
            ras_ptr <= ras_ptr + PW'(1);
            if (!ras_full)
                ras_count <= ras_count + CW'(1);
        end else if (do_pop && !ras_empty) begin
            ras_ptr   <= top_idx;
            ras_count <= ras_count - CW'(1);
        end
    end

    assign RASEmpty = ras_empty;
    assign RASTop   = ras_empty ? '0 : ras_mem[top_idx];
    assign RASMiss  = !Reset && Return && JumpReg &&
                      (ras_empty || (ras_mem[top_idx] != RegTarget));
`else
    logic unused_ras;

    assign unused_ras = &{1'b0, Link, Return};
    assign RASTop     = '0;
    assign RASEmpty   = 1'b1;
    assign RASMiss    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations for the stack outputs follow
// whether PC_SEQUENCER_RAS_EN is defined for the build.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        CLK;
    logic        Reset;
    logic        Stall;
    logic        Branch;
    logic        ALUZero;
    logic        Jump;
    logic        JumpReg;
    logic        Exception;
    logic        Link;
    logic        Return;
    logic [25:0] JumpField;
    logic [31:0] SignExtImm32;
    logic [31:0] RegTarget;
    logic [31:0] CurrentPC;
    logic [31:0] NextPC;
    logic [31:0] PCPlus4;
    logic [31:0] RASTop;
    logic        RASEmpty;
    logic        RASMiss;

    int total;
    int passed;

    pc_sequencer #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h0040_0000),
        .EXC_VECTOR  (32'h8000_0180),
        .RAS_DEPTH   (4)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Stall       (Stall),
        .Branch      (Branch),
        .ALUZero     (ALUZero),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .Exception   (Exception),
        .Link        (Link),
        .Return      (Return),
        .JumpField   (JumpField),
        .SignExtImm32(SignExtImm32),
        .RegTarget   (RegTarget),
        .CurrentPC   (CurrentPC),
        .NextPC      (NextPC),
        .PCPlus4     (PCPlus4),
        .RASTop      (RASTop),
        .RASEmpty    (RASEmpty),
        .RASMiss     (RASMiss)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Stall = 0; Branch = 0; ALUZero = 0; Jump = 0; JumpReg = 0;
        Exception = 0; Link = 0; Return = 0;
        JumpField = '0; SignExtImm32 = '0; RegTarget = '0;
    endtask

    task automatic chk_ras(input string tag, input logic [31:0] top,
                           input logic empty, input logic miss);
        chk({tag, "_top"},   RASTop,          RAS ? top : 32'h0);
        chk({tag, "_empty"}, {31'b0, RASEmpty}, {31'b0, RAS ? empty : 1'b1});
        chk({tag, "_miss"},  {31'b0, RASMiss},  {31'b0, RAS ? miss : 1'b0});
    endtask

    // One stack pop as a jr $ra returning to target.
    task automatic pop(input string tag, input logic [31:0] target,
                       input logic [31:0] top, input logic empty, input logic miss);
        idle();
        JumpReg = 1; Return = 1; RegTarget = target;
        #1;
        chk_ras(tag, top, empty, miss);
        chk({tag, "_next"}, NextPC, target);
        step();
        chk({tag, "_pc"}, CurrentPC, target);
    endtask

    initial begin
        logic [31:0] ret_a [5];
        total  = 0;
        passed = 0;
        idle();
        Reset = 1;
        #2;
        chk("por_pc", CurrentPC, 32'h0040_0000);
        @(negedge CLK);
        Reset = 0;
        step();
        chk("run_pc1", CurrentPC, 32'h0040_0004);
        step();
        chk("run_pc2", CurrentPC, 32'h0040_0008);

        // Mid-cycle reset with a return request pending: miss must stay low.
        #2;
        JumpReg = 1; Return = 1; RegTarget = 32'h1234_5678;
        Reset = 1;
        #1;
        chk("rst_async_pc", CurrentPC, 32'h0040_0000);
        chk("rst_top", RASTop, 32'h0);
        chk("rst_empty", {31'b0, RASEmpty}, 32'h1);
        chk("rst_miss", {31'b0, RASMiss}, 32'h0);
        step();
        chk("rst_hold_pc", CurrentPC, 32'h0040_0000);
        idle();
        #2;
        Reset = 0;
        step();
        chk("rst_release_pc", CurrentPC, 32'h0040_0004);
        step();
        step();
        step();
        chk("pc_0010", CurrentPC, 32'h0040_0010);
        chk("plus4", PCPlus4, 32'h0040_0014);

        // Next-PC priority ladder.
        Branch = 1; ALUZero = 1; Jump = 1; SignExtImm32 = 32'd3; JumpField = 26'h010_0040;
        #1;
        chk("pri_branch", NextPC, 32'h0040_0020);
        JumpReg = 1; RegTarget = 32'h0040_1000;
        #1;
        chk("pri_jumpreg", NextPC, 32'h0040_1000);
        Exception = 1;
        #1;
        chk("pri_exc", NextPC, 32'h8000_0180);
        Exception = 0; JumpReg = 0; ALUZero = 0;
        #1;
        chk("pri_jump", NextPC, 32'h0040_0100);
        SignExtImm32 = 32'hFFFF_FFFC; ALUZero = 1;
        #1;
        chk("branch_back", NextPC, 32'h0040_0004);

        // Stall holds the PC; exception breaks through.
        idle();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", CurrentPC, 32'h0040_0010);
        end
        Exception = 1;
        step();
        chk("stall_exc", CurrentPC, 32'h8000_0180);

        idle();
        JumpReg = 1; RegTarget = 32'h0040_0008;
        step();
        chk("jr_pc", CurrentPC, 32'h0040_0008);

        // jal / jr $ra pair.
        idle();
        Jump = 1; Link = 1; JumpField = 26'h010_0040;
        step();
        chk("jal_pc", CurrentPC, 32'h0040_0100);
        chk_ras("jal", 32'h0040_000C, 1'b0, 1'b0);
        pop("ret", 32'h0040_000C, 32'h0040_000C, 1'b0, 1'b0);
        chk_ras("ret_after", 32'h0, 1'b1, 1'b0);

        // An uncommitted (stalled) call must not push.
        idle();
        Stall = 1; Link = 1;
        step();
        chk_ras("stall_link", 32'h0, 1'b1, 1'b0);

        // Five pushes into a four-entry stack overwrite the oldest.
        for (int i = 0; i < 5; i++) begin
            idle();
            Link = 1;
            ret_a[i] = 32'h0040_0010 + 32'(4 * i);
            step();
            chk("push_top", RASTop, RAS ? ret_a[i] : 32'h0);
        end
        chk("push_pc", CurrentPC, 32'h0040_0020);
        for (int i = 4; i >= 1; i--)
            pop("wrap_pop", ret_a[i], ret_a[i], 1'b0, 1'b0);
        pop("wrap_under", ret_a[0], 32'h0, 1'b1, 1'b1);
        chk_ras("under_after", 32'h0, 1'b1, 1'b0);

        // jalr through $ra: replace, starting from an empty stack.
        idle();
        Link = 1; Return = 1; JumpReg = 1; RegTarget = 32'h0040_0100;
        step();
        chk("jalr_pc", CurrentPC, 32'h0040_0100);
        chk_ras("jalr1", 32'h0040_0014, 1'b0, 1'b0);
        RegTarget = 32'h0040_0200;
        #1;
        chk("jalr2_miss", {31'b0, RASMiss}, {31'b0, RAS});
        step();
        chk_ras("jalr2", 32'h0040_0104, 1'b0, 1'b0);

        // Exception with Link set leaves the stack alone.
        idle();
        Link = 1; Exception = 1;
        step();
        chk("exc_pc", CurrentPC, 32'h8000_0180);
        chk_ras("exc", 32'h0040_0104, 1'b0, 1'b0);

        idle();
        step();
        chk("final_pc", CurrentPC, 32'h8000_0184);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/target width; legal values >= 32.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h8000_0180, exception handler address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; legal values are powers of 2 from 2 to 16.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port Stall, input, 1, hold the PC.
REQ-008 SHALL have ports Branch, ALUZero, Jump, JumpReg, Exception, each input, 1: taken-branch qualifiers, jump, jump-register and exception request.
REQ-009 SHALL have ports Link and Return, each input, 1: call (jal/jalr) and return (jr $ra) markers.
REQ-010 SHALL have port JumpField, input, 26, jump target field.
REQ-011 SHALL have ports SignExtImm32 and RegTarget, each input, WIDTH: branch immediate and register target.
REQ-012 SHALL have ports CurrentPC, NextPC and PCPlus4, each output, WIDTH: registered PC, combinational next PC and CurrentPC+4.
REQ-013 SHALL have ports RASTop (output, WIDTH), RASEmpty (output, 1) and RASMiss (output, 1): predicted return, stack empty, and return mispredict pulse.

Function
REQ-014 SHALL compute PCPlus4 = CurrentPC + 4, modulo 2^WIDTH.
REQ-015 SHALL select NextPC by fixed priority, first match wins:
- Exception: EXC_VECTOR
- JumpReg: RegTarget
- Branch && ALUZero: PCPlus4 + (SignExtImm32 << 2), mod 2^WIDTH
- Jump: {PCPlus4[WIDTH-1:28], JumpField, 2'b00}
- otherwise: PCPlus4
REQ-016 SHALL set CurrentPC <= NextPC on each rising CLK edge when Stall=0, giving a one-cycle latency from inputs to CurrentPC.
REQ-017 SHALL hold CurrentPC when Stall=1, unless Exception=1; Exception overrides Stall.
REQ-018 SHALL treat a cycle as committed only when Stall=0 or Exception=1; an uncommitted cycle SHALL NOT change any state.
REQ-019 SHALL produce NextPC, PCPlus4, RASTop, RASEmpty and RASMiss combinationally, with no added cycle.

Reset
REQ-020 SHALL, while Reset=1 and independent of CLK, force CurrentPC = RESET_VECTOR, stack pointer = 0 and entry count = 0.
REQ-021 SHALL, as a consequence of REQ-020, present RASEmpty=1, RASTop=0 and RASMiss=0 during reset.
REQ-022 SHALL abort any update in progress when Reset asserts mid-cycle; the first rising edge after deassertion SHALL load NextPC normally.

Configuration
REQ-023 SHALL use macro PC_SEQUENCER_RAS_EN to compile the return-address stack in or out.
REQ-024 SHALL, with PC_SEQUENCER_RAS_EN defined, operate the stack as a circular buffer of RAS_DEPTH entries with a pointer and a saturating count 0..RAS_DEPTH.
- Committed non-exception cycle with Link=1 and Return=0: push PCPlus4; when the stack is full, overwrite the oldest entry (wrap) and keep count = RAS_DEPTH.
- Committed cycle with JumpReg=1, Return=1 and Link=0: pop; on empty, leave pointer and count unchanged.
- Return and Link both set (jalr through $ra): replace the top entry with PCPlus4; count unchanged, or count = 1 if the stack was empty.
REQ-025 SHALL, with PC_SEQUENCER_RAS_EN defined, assert RASMiss during a Return && JumpReg cycle when RASEmpty=1 or RASTop != RegTarget.
REQ-026 SHALL, with PC_SEQUENCER_RAS_EN defined, always take NextPC from RegTarget regardless of the prediction, and SHALL NOT let Exception alter the stack.
REQ-027 SHALL, without PC_SEQUENCER_RAS_EN, include no stack storage and tie RASTop=0, RASEmpty=1 and RASMiss=0.

Verification
REQ-028 SHALL cover reset: assert Reset mid-cycle with RESET_VECTOR=32'h0040_0000 -> CurrentPC=32'h0040_0000 immediately, and 32'h0040_0004 one edge after release.
REQ-029 SHALL cover priority: CurrentPC=32'h0040_0010, Branch=ALUZero=Jump=1, SignExtImm32=3 -> NextPC=32'h0040_0020; adding JumpReg=1 with RegTarget=32'h0040_1000 -> NextPC=32'h0040_1000.
REQ-030 SHALL cover stall/exception: Stall=1 for 3 edges -> CurrentPC unchanged; Stall=1 with Exception=1 -> CurrentPC=32'h8000_0180 next edge.
REQ-031 SHALL cover RAS push/pop: jal at PC=32'h0040_0008 -> RASTop=32'h0040_000C; return with RegTarget=32'h0040_000C -> RASMiss=0 and RASEmpty=1 after the edge.
REQ-032 SHALL cover RAS wrap: RAS_DEPTH=4 with 5 pushes of A..E, then 4 pops -> tops E, D, C, B; 5th pop with RegTarget=A -> RASMiss=1.
REQ-033 SHALL cover build without PC_SEQUENCER_RAS_EN: same jal/return sequence -> identical PC trace, RASEmpty=1 and RASMiss=0 throughout.
